// File: rtl/srp_buf_pkg.sv
// Shared constants, state encoding and circular-address helpers for the
// Shapiro-Rudin-Park sample buffer controller.
package srp_buf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2096;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CAPTURE = 1'b0,
        READ    = 1'b1
    } state_e;

    // (a - b) mod DEPTH for operands already inside 0..DEPTH-1.
    function automatic logic [ADDR_W-1:0] wrap_sub(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        logic [ADDR_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[ADDR_W]) begin
            diff = diff + DEPTH_X;
        end
        return diff[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/srp_out_skid.sv
// Two-entry output FIFO between the BRAM read port and the downstream
// valid/ready consumer; the caller only pushes when a slot is guaranteed.
module srp_out_skid #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_idx_q;
    logic         rd_idx_q;
    logic [1:0]   cnt_q;
    logic         pop;

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_idx_q];
    assign count_o     = cnt_q;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (in_valid_i) begin
                mem_q[wr_idx_q] <= in_data_i;
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            cnt_q <= cnt_q + {1'b0, in_valid_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/srp_capture_buf_ctrl.sv
// Circular capture into the sample BRAM, then frame readout on sync detection.
// Build option SRP_DROP_CNT_EN adds a saturating count of samples dropped during READ.
module srp_capture_buf_ctrl
    import srp_buf_pkg::*;
#(
    parameter int FRAME_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              sync_pulse,
    input  logic [ADDR_W-1:0] sync_offset,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_di,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
`ifdef SRP_DROP_CNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  issued_q;
    logic              inflight_q;
    logic              inflight_last_q;

    logic              issue;
    logic              wr_fire;
    logic              pop;
    logic              can_issue;
    logic [2:0]        occ;
    logic [1:0]        skid_cnt;
    logic [DATA_W:0]   skid_data;
    logic [ADDR_W-1:0] newest;
    logic [ADDR_W-1:0] off_clamped;
    logic [ADDR_W-1:0] start_addr;

    assign busy   = busy_q;
    assign pop    = m_valid & m_ready;
    assign m_data = skid_data[DATA_W-1:0];
    assign m_last = skid_data[DATA_W];

    always_comb begin
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = '0;
        bram_di     = '0;
        issue       = 1'b0;
        wr_fire     = 1'b0;
        // Slots freed by this cycle's handshake count, so 1 sample/cycle is sustainable.
        occ         = {1'b0, skid_cnt} - {2'b0, pop} + {2'b0, inflight_q};
        can_issue   = (issued_q < CNT_W'(FRAME_LEN)) && (occ < 3'd2);
        newest      = s_valid ? wr_ptr_q : wrap_sub(wr_ptr_q, ADDR_W'(1));
        off_clamped = (sync_offset > LAST_ADDR) ? LAST_ADDR : sync_offset;
        start_addr  = wrap_sub(newest, off_clamped);
        rd_ptr_d    = rd_ptr_q;

        if (!rst) begin
            case (state_q)
                CAPTURE: begin
                    if (s_valid) begin
                        bram_en   = 1'b1;
                        bram_we   = 1'b1;
                        bram_addr = wr_ptr_q;
                        bram_di   = s_data;
                        wr_fire   = 1'b1;
                    end
                    if (sync_pulse) begin
                        rd_ptr_d = start_addr;
                    end
                end
                READ: begin
                    if (can_issue) begin
                        bram_en   = 1'b1;
                        bram_addr = rd_ptr_q;
                        issue     = 1'b1;
                        rd_ptr_d  = wrap_inc(rd_ptr_q);
                    end
                end
                default: ;
            endcase
        end

        wr_ptr_d = wr_fire ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= CAPTURE;
            busy_q          <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= issue;
            if (issue) begin
                issued_q        <= issued_q + 1'b1;
                inflight_last_q <= (issued_q == CNT_W'(FRAME_LEN - 1));
            end
            case (state_q)
                CAPTURE: begin
                    if (sync_pulse) begin
                        state_q  <= READ;
                        busy_q   <= 1'b1;
                        issued_q <= '0;
                    end
                end
                READ: begin
                    if (pop && m_last) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= CAPTURE;
            endcase
        end
    end

`ifdef SRP_DROP_CNT_EN
    logic [15:0] drop_q;

    assign drop_count = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 16'h0000;
        end else if (state_q == READ && s_valid && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'h0001;
        end
    end
`endif

    srp_out_skid #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (inflight_q),
        .in_data_i  ({inflight_last_q, bram_dout}),
        .out_valid_o(m_valid),
        .out_ready_i(m_ready),
        .out_data_o (skid_data),
        .count_o    (skid_cnt)
    );

endmodule
